rle_zero_decoder: RTL and testbench

- Receive-side inverse of the DWT + hard-threshold + zero-run-length chain in System 1.
- Consumes a token stream of literal coefficients and zero-run tokens. Re-expands it into one signed coefficient per output handshake, framed into fixed DWT blocks.
- Sits between the compressed-stream source (memory or link) and the inverse-DWT stage.
- Fully sequential: run counter, block position counter, valid/ready on both sides.

---
 rtl/system1_pkg.sv | 15 +
 rtl/block_pos_counter.sv | 24 ++
 rtl/rle_zero_decoder.sv | 99 +++++++++
 tb/tb_rle_zero_decoder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/system1_pkg.sv
// Constants and types shared by the System 1 coefficient encoder and decoder.
package system1_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int BLOCK_LEN_DEF = 64;

  localparam logic FLAG_LIT = 1'b0;
  localparam logic FLAG_RUN = 1'b1;

  typedef enum logic {
    ACCEPT = 1'b0,
    RUN    = 1'b1
  } state_t;

endpackage

// File: rtl/block_pos_counter.sv
// Wrapping modulo-BLOCK_LEN sample position counter; pos is the slot the next
// loaded sample will occupy, and is_last flags slot BLOCK_LEN-1.
module block_pos_counter #(
  parameter  int BLOCK_LEN = 64,
  localparam int CNT_W     = $clog2(BLOCK_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] pos,
  output logic             is_last
);

  assign is_last = (pos == CNT_W'(BLOCK_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else if (inc) begin
      pos <= is_last ? '0 : pos + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rle_zero_decoder.sv
// Expands literal / zero-run tokens into one coefficient per output handshake,
// 1-cycle token-to-output latency; runs stall in_ready and are cut at block ends.
module rle_zero_decoder
  import system1_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BLOCK_LEN = BLOCK_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_flag,
  input  logic [DATA_W-1:0] in_payload,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              overrun
);

  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam logic [DATA_W:0] REM_ONE = (DATA_W + 1)'(1);

  state_t            state;
  logic [DATA_W:0]   rem;
  logic [DATA_W:0]   run_len;
  logic [DATA_W:0]   next_rem;
  logic              free;
  logic              accept;
  logic              accept_run;
  logic              run_load;
  logic              load;
  logic              zero_load;
  logic              pos_last;
  logic              truncate;
  logic [CNT_W-1:0]  unused_pos;

  assign free       = !out_valid | out_ready;
  assign in_ready   = !rst & (state == ACCEPT) & free;
  assign accept     = in_valid & in_ready;
  assign accept_run = accept & (in_flag == FLAG_RUN);
  assign run_load   = (state == RUN) & free;
  assign load       = accept | run_load;
  assign zero_load  = run_load | accept_run;

  // Payload 0 stands for the longest run, 2^DATA_W zeros.
  assign run_len = (in_payload == '0) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, in_payload};

  always_comb begin
    next_rem = '0;
    if (run_load) begin
      next_rem = rem - REM_ONE;
    end else if (accept_run) begin
      next_rem = run_len - REM_ONE;
    end
  end

  // A run reaching the last slot of a block is dropped rather than spilled.
  assign truncate = zero_load & pos_last & (next_rem != '0);

  block_pos_counter #(
    .BLOCK_LEN(BLOCK_LEN)
  ) u_pos (
    .clk    (clk),
    .rst    (rst),
    .inc    (load),
    .pos    (unused_pos),
    .is_last(pos_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCEPT;
      rem       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= truncate;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= zero_load ? '0 : in_payload;
        out_last  <= pos_last;
        if (truncate || next_rem == '0) begin
          rem   <= '0;
          state <= ACCEPT;
        end else begin
          rem   <= next_rem;
          state <= RUN;
        end
      end else if (free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rle_zero_decoder.sv
// Randomized and directed bench for rle_zero_decoder against a token-expansion queue model.
module tb_rle_zero_decoder;
  import system1_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       in_flag = 1'b0;
  logic [7:0] in_payload = 8'h00;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_last, overrun;
  logic [7:0] out_data;

  logic       b_in_valid = 1'b0;
  logic       b_in_flag = 1'b1;
  logic [7:0] b_in_payload = 8'h00;
  logic       b_out_ready = 1'b1;
  logic       b_in_ready, b_out_valid, b_out_last, b_overrun;
  logic [7:0] b_out_data;

  rle_zero_decoder #(.DATA_W(8), .BLOCK_LEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_flag(in_flag),
    .in_payload(in_payload), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .overrun(overrun)
  );

  rle_zero_decoder #(.DATA_W(8), .BLOCK_LEN(512)) dut_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_flag(b_in_flag),
    .in_payload(b_in_payload), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .overrun(b_overrun)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: each accepted token becomes its list of expected samples.
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t expq[$];
  int   mpos = 0;
  int   exp_ovr = 0;

  task automatic model_token(input logic flag, input logic [7:0] p);
    int n;
    bit lst;
    if (flag == FLAG_LIT) begin
      expq.push_back('{data: p, last: (mpos == 63)});
      mpos = (mpos + 1) % 64;
    end else begin
      n = (p == 8'h00) ? 256 : int'(p);
      for (int k = 0; k < n; k++) begin
        lst = (mpos == 63);
        expq.push_back('{data: 8'h00, last: lst});
        mpos = (mpos + 1) % 64;
        if (lst && k < n - 1) begin
          exp_ovr++;
          break;
        end
      end
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   stall_pct = 0;
  bit   rdy_pat[$];
  always @(posedge clk) begin
    #1;
    if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
    else out_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
  end

  int         n_cons = 0;
  int         n_ovr = 0;
  int         cons_cyc[$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (overrun) begin
        n_ovr++;
        check("overrun_sample", {out_valid, out_last, out_data}, {2'b11, 8'h00});
      end
      if (out_valid && out_ready) begin
        n_cons++;
        cons_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          check("extra_sample", 1, 0);
        end else begin
          e = expq.pop_front();
          check("data", out_data, e.data);
          check("last", out_last, e.last);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  int b_cnt = 0, b_bad = 0, b_last = 0, b_ovr = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (b_out_valid && b_out_ready) begin
        b_cnt++;
        if (b_out_data != 8'h00) b_bad++;
        if (b_out_last) b_last++;
      end
      if (b_overrun) b_ovr++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the token is taken.
  task automatic send(input logic flag, input logic [7:0] p, output int acc, output int waits);
    in_valid = 1'b1;
    in_flag = flag;
    in_payload = p;
    waits = 0;
    acc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        model_token(flag, p);
        break;
      end
      waits++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc < 0) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      if (expq.size() == 0) break;
    end
    check("drain", expq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expq.delete();
    mpos = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc[5];
    int w[5];
    int base, ovr0, eovr0, r, nidle;
    logic       f;
    logic [7:0] p;

    @(negedge clk);
    check("reset_outputs", {in_ready, out_valid, out_last, overrun, out_data}, 12'h000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back literals
    cons_cyc.delete();
    send(FLAG_LIT, 8'h05, acc[0], w[0]);
    send(FLAG_LIT, 8'hFD, acc[1], w[1]);
    send(FLAG_LIT, 8'h00, acc[2], w[2]);
    wait_drain(50);
    check("lit_ready_waits", w[0] + w[1] + w[2], 0);
    check("lit_count", cons_cyc.size(), 3);
    for (int i = 0; i < 3; i++) check("lit_latency", cons_cyc[i], acc[i] + 1);

    // Run of 4 followed by a literal
    cons_cyc.delete();
    send(FLAG_RUN, 8'd4, acc[0], w[0]);
    send(FLAG_LIT, 8'd7, acc[1], w[1]);
    wait_drain(50);
    check("run_ready_low", w[1], 3);
    check("run_count", cons_cyc.size(), 5);
    for (int i = 0; i < 5; i++) check("run_cycle", cons_cyc[i], acc[0] + 1 + i);

    // Run of 3 under backpressure
    base = n_cons;
    @(negedge clk);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    @(posedge clk);
    #1;
    send(FLAG_RUN, 8'd3, acc[0], w[0]);
    wait_drain(50);
    check("bp_zeros", n_cons - base, 3);

    // Block boundary truncation
    do_reset();
    base = n_cons;
    ovr0 = n_ovr;
    for (int i = 1; i <= 60; i++) send(FLAG_LIT, 8'(i), acc[0], w[0]);
    send(FLAG_RUN, 8'd10, acc[0], w[0]);
    send(FLAG_LIT, 8'h11, acc[0], w[0]);
    wait_drain(200);
    check("trunc_samples", n_cons - base, 65);
    check("trunc_overrun", n_ovr - ovr0, 1);

    // Payload 0 run on a 512-sample block
    b_in_valid = 1'b1;
    r = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_in_ready) begin
        r = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    check("big_accept", r, 1);
    repeat (300) @(posedge clk);
    check("big_run_len", b_cnt, 256);
    check("big_nonzero", b_bad, 0);
    check("big_last", b_last, 0);
    check("big_overrun", b_ovr, 0);
    #1;

    // Reset in the middle of a run
    base = n_cons;
    send(FLAG_RUN, 8'd200, acc[0], w[0]);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (n_cons - base >= 50) break;
    end
    check("mid_run_zeros", n_cons - base, 50);
    rst = 1'b1;
    expq.delete();
    mpos = 0;
    #1;
    check("async_reset_outputs", {in_ready, out_valid, out_last, overrun, out_data}, 12'h000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", in_ready, 1);
    @(posedge clk);
    #1;
    base = n_cons;
    send(FLAG_LIT, 8'h2A, acc[0], w[0]);
    wait_drain(50);
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_samples", n_cons - base, 1);

    // Random token stream with random backpressure
    do_reset();
    stall_pct = 30;
    ovr0 = n_ovr;
    eovr0 = exp_ovr;
    for (int t = 0; t < 150; t++) begin
      f = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (f == FLAG_LIT) p = 8'($urandom);
      else if (r == 0) p = 8'h00;
      else if (r < 3) p = 8'($urandom_range(1, 255));
      else p = 8'($urandom_range(1, 12));
      send(f, p, acc[0], w[0]);
      if ($urandom_range(0, 3) == 0) begin
        nidle = $urandom_range(1, 3);
        repeat (nidle) @(posedge clk);
        #1;
      end
    end
    wait_drain(5000);
    check("rand_overruns", n_ovr - ovr0, exp_ovr - eovr0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
